// File: rtl/genius_input_if.sv
// Bus between the button collector and its host: raw buttons, round control,
// the expected-symbol lookup and the press/round result outputs.
interface genius_input_if;
  logic       bt0;
  logic       bt1;
  logic       bt2;
  logic       start;
  logic [4:0] round_len;
  logic [1:0] exp_sym;
  logic [3:0] exp_idx;
  logic       busy;
  logic       press_valid;
  logic [1:0] press_sym;
  logic       round_ok;
  logic       round_fail;
  logic [1:0] fail_code;

  modport master (
    output bt0, bt1, bt2, start, round_len, exp_sym,
    input  exp_idx, busy, press_valid, press_sym, round_ok, round_fail, fail_code
  );

  modport slave (
    input  bt0, bt1, bt2, start, round_len, exp_sym,
    output exp_idx, busy, press_valid, press_sym, round_ok, round_fail, fail_code
  );
endinterface

// File: rtl/genius_input.sv
// Button input collector: synchronises and debounces three push-buttons,
// turns debounced rising edges into press events and checks a round of
// presses against the expected sequence, reporting success, wrong symbol,
// timeout or multiple simultaneous buttons.
module genius_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic         clock,
  input  logic         reset,
  genius_input_if.slave bus
);

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

  logic [2:0]  raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  deb;
  logic [2:0]  deb_d;
  logic [7:0]  deb_cnt [3];
  logic [2:0]  rise;
  logic        press_evt;
  logic        multi;
  logic [1:0]  rise_sym;

  state_t      state;
  logic [3:0]  exp_idx_q;
  logic [4:0]  len_q;
  logic [19:0] tmo_cnt;
  logic [1:0]  cap_sym;
  logic        cap_multi;
  logic        press_valid_q;
  logic [1:0]  press_sym_q;
  logic        round_ok_q;
  logic        round_fail_q;
  logic [1:0]  fail_code_q;

  assign raw = {bus.bt2, bus.bt1, bus.bt0};

  // Two-flop synchroniser bringing the asynchronous buttons into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level follows the synchronised value after enough disagreeing cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Press event detection on debounced rising edges, with symbol encoding
  always_comb begin
    rise      = deb & ~deb_d;
    press_evt = |rise;
    multi     = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    rise_sym  = 2'b00;
    if (rise[2])      rise_sym = 2'b10;
    else if (rise[1]) rise_sym = 2'b01;
  end

  // Press outputs: pulse on every event, symbol only updated on single-button events
  always_ff @(posedge clock) begin
    if (reset) begin
      press_valid_q <= 1'b0;
      press_sym_q   <= 2'b00;
    end else begin
      press_valid_q <= press_evt;
      if (press_evt && !multi) press_sym_q <= rise_sym;
    end
  end

  // Round state machine: waits for presses, checks each against exp_sym
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      exp_idx_q    <= '0;
      len_q        <= '0;
      tmo_cnt      <= '0;
      cap_sym      <= 2'b00;
      cap_multi    <= 1'b0;
      round_ok_q   <= 1'b0;
      round_fail_q <= 1'b0;
      fail_code_q  <= 2'b00;
    end else begin
      round_ok_q   <= 1'b0;
      round_fail_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.round_len != 5'd0) && (bus.round_len <= 5'd16)) begin
            state       <= WAIT;
            exp_idx_q   <= '0;
            len_q       <= bus.round_len;
            tmo_cnt     <= '0;
            fail_code_q <= 2'b00;
          end
        end
        WAIT: begin
          if (press_evt) begin
            cap_sym   <= rise_sym;
            cap_multi <= multi;
            state     <= CHECK;
          end else if (tmo_cnt == TO_LAST) begin
            round_fail_q <= 1'b1;
            fail_code_q  <= 2'b10;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
          end
        end
        CHECK: begin
          if (cap_multi) begin
            round_fail_q <= 1'b1;
            fail_code_q  <= 2'b11;
            state        <= IDLE;
          end else if (cap_sym != bus.exp_sym) begin
            round_fail_q <= 1'b1;
            fail_code_q  <= 2'b01;
            state        <= IDLE;
          end else if (({1'b0, exp_idx_q} + 5'd1) == len_q) begin
            round_ok_q <= 1'b1;
            state      <= IDLE;
          end else begin
            exp_idx_q <= exp_idx_q + 4'd1;
            tmo_cnt   <= '0;
            state     <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.exp_idx     = exp_idx_q;
  assign bus.busy        = (state != IDLE);
  assign bus.press_valid = press_valid_q;
  assign bus.press_sym   = press_sym_q;
  assign bus.round_ok    = round_ok_q;
  assign bus.round_fail  = round_fail_q;
  assign bus.fail_code   = fail_code_q;

endmodule

// File: doc/genius_input.md
GENIUS_INPUT -- requirements
Module: genius_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, sets the number of consecutive stable cycles a synchronised button must hold before its debounced level changes (1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, sets the maximum cycles allowed in WAIT without an accepted press (1..2^20-1).
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bt0, bt1, bt2  input  1 each  raw asynchronous push-buttons, high = pressed; encode symbols 2'b00, 2'b01, 2'b10.
REQ-006 start  input  1  one-cycle request to begin collecting a round.
REQ-007 round_len  input  5  number of symbols in the round, valid 1..16, sampled on accepted start.
REQ-008 exp_sym  input  2  expected symbol at exp_idx, supplied combinationally by the sequence store.
REQ-009 exp_idx  output  4  index of the symbol currently awaited.
REQ-010 busy  output  1  high while a round is being collected (any state except IDLE).
REQ-011 press_valid  output  1  one-cycle pulse per debounced press event.
REQ-012 press_sym  output  2  symbol of the press event; valid with press_valid, else holds last value.
REQ-013 round_ok  output  1  one-cycle pulse, entire round entered correctly.
REQ-014 round_fail  output  1  one-cycle pulse, round aborted by error.
REQ-015 fail_code  output  2  cause, valid with round_fail, held until next start: 01 wrong symbol, 10 timeout, 11 multiple buttons.

Function
REQ-016 Each button SHALL pass a 2-flop synchroniser, then a per-button debounce counter; the debounced level SHALL take the synchronised value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement cycle clears the counter.
REQ-017 A press event SHALL be a 0->1 transition of a debounced level; a constantly held button SHALL produce exactly one event; release produces none.
REQ-018 press_valid SHALL assert exactly 2+DEBOUNCE_CYCLES cycles after the first edge sampling a raw button high, provided it stays high throughout.
REQ-019 Two or more debounced rising edges in the same cycle SHALL form one event flagged multi; press_valid asserts, press_sym holds its prior value.
REQ-020 States: IDLE, WAIT, CHECK.
REQ-021 IDLE -> WAIT on start with round_len in 1..16: exp_idx <= 0, press counter <= 0, timeout counter <= 0, fail_code <= 00; start with round_len 0 or 17..31 SHALL be ignored.
REQ-022 start while busy SHALL be ignored.
REQ-023 WAIT: on press event, capture symbol and multi flag, go CHECK; timeout counter increments each WAIT cycle without an event.
REQ-024 WAIT: timeout counter reaching TIMEOUT_CYCLES SHALL pulse round_fail with fail_code 10 and return to IDLE on the same edge.
REQ-025 CHECK (one cycle): multi -> round_fail, fail_code 11, IDLE; captured symbol != exp_sym -> round_fail, fail_code 01, IDLE; match with exp_idx+1 == round_len -> round_ok, IDLE; match otherwise -> exp_idx+1, timeout counter cleared, WAIT.
REQ-026 round_ok/round_fail SHALL assert in the cycle after CHECK is entered, i.e. one cycle after press_valid; never simultaneously.
REQ-027 Press events occurring in IDLE or CHECK SHALL still pulse press_valid but SHALL NOT affect the round.
REQ-028 exp_idx SHALL not wrap; round_len=16 completes at index 15.

Reset
REQ-029 reset SHALL force IDLE, synchronisers, debounced levels and all counters to 0, and all outputs to 0 on the next edge.
REQ-030 reset mid-round SHALL abort silently: no round_ok or round_fail pulse.
REQ-031 Buttons held high through reset release SHALL generate a press event after debounce (debounced level restarts at 0).

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-032 bt1 high from edge 0, held 20 cycles -> single press_valid at edge 6, press_sym=01; glitch of 3 cycles -> no event.
REQ-033 start, round_len=3, exp_sym sequence 00,01,10; press bt0, bt1, bt2 -> exp_idx 0->1->2, round_ok one cycle after third press_valid, busy low after.
REQ-034 start, round_len=2, exp_sym 01; press bt2 -> round_fail, fail_code 01, exp_idx stays 0.
REQ-035 start, no press for 50 cycles -> round_fail with fail_code 10 at 50th WAIT cycle.
REQ-036 bt0 and bt2 asserted same edge in WAIT -> round_fail, fail_code 11; start with round_len=0 or 17 -> busy stays 0.
REQ-037 reset asserted in WAIT after one correct press -> state IDLE, exp_idx=0, no result pulse.
